mem_bus_arbiter: RTL and testbench

- Arbitrates one external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage), so the core can run from a single unified SRAM.
- Sequences every transaction: grant, address/data hold until the bus acknowledges, one-cycle response, then re-arbitration.
- Generates the stall requests that the pipeline ctrl block folds into stall[5:0].
- Bounds starvation of the fetch port and aborts bus accesses that never acknowledge.

---
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the fetch port and the data port.
// Each access runs grant -> hold until bus_ack_i (or timeout) -> one response cycle -> re-arbitrate.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_sel_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        timeout_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  // Last waiting cycle index; the abort happens on the TIMEOUT-th cycle without an ack.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy, StResp} state_e;

  state_e             state;
  logic [StarveW-1:0] starve_cnt;
  logic [7:0]         tmo_cnt;

  logic fetch_wins;
  assign fetch_wins = if_req_i && (starve_cnt == StarveMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      d_rdata_o   <= '0;
      d_ack_o     <= 1'b0;
      timeout_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      d_ack_o   <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        StIdle: begin
          tmo_cnt <= '0;
          if (d_req_i && !fetch_wins) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= d_we_i;
            bus_addr_o  <= d_addr_i;
            bus_wdata_o <= d_wdata_i;
            bus_sel_o   <= d_sel_i;
            state       <= StDBusy;
            if (!if_req_i) begin
              starve_cnt <= '0;
            end else if (starve_cnt != StarveMax) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (if_req_i) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_sel_o   <= 4'hF;
            starve_cnt  <= '0;
            state       <= StIfBusy;
          end else begin
            starve_cnt <= '0;
          end
        end
        StIfBusy, StDBusy: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state     <= StResp;
            if (state == StIfBusy) begin
              if_rdata_o <= bus_rdata_i;
              if_ack_o   <= 1'b1;
            end else begin
              d_rdata_o <= bus_rdata_i;
              d_ack_o   <= 1'b1;
            end
          end else if (tmo_cnt == TmoLast) begin
            bus_req_o <= 1'b0;
            timeout_o <= 1'b1;
            state     <= StResp;
            if (state == StIfBusy) begin
              if_rdata_o <= '0;
              if_ack_o   <= 1'b1;
            end else begin
              d_rdata_o <= '0;
              d_ack_o   <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        StResp: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = d_req_i & ~d_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single transactions plus hand-written
// sequences for arbitration fairness, timeout, reset abort and ack-on-timeout-cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        timeout_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_ack_o       (if_ack_o),
    .d_req_i        (d_req_i),
    .d_we_i         (d_we_i),
    .d_addr_i       (d_addr_i),
    .d_wdata_i      (d_wdata_i),
    .d_sel_i        (d_sel_i),
    .d_rdata_o      (d_rdata_o),
    .d_ack_o        (d_ack_o),
    .timeout_o      (timeout_o),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_sel_o      (bus_sel_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          waits;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_bus_req(input string name);
    for (int k = 0; k < 10 && !bus_req_o; k++) tick();
    check(name, 32'(bus_req_o), 32'd1);
  endtask

  logic [31:0] model_if_rdata;
  logic [31:0] model_d_rdata;
  int          busy_cycles;
  logic        exp_is_d;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h3, 32'hDEAD_BEEF, 2,
                1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 32'h0BAD_F00D, 0,
                1'b1, 4'b0011, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'hA5A5_A5A5, 4'hF, 32'h55AA_1234, 1,
                1'b0, 4'hF, 32'hA5A5_A5A5};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 32'h1357_9BDF, 0,
                1'b0, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_2003, 32'h0000_00EE, 4'b1000, 32'h7777_0000, 3,
                1'b1, 4'b1000, 32'h0000_00EE};

    rst = 1'b1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_wdata_i = 0; d_sel_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    model_if_rdata = 0; model_d_rdata = 0;
    tick(); tick();
    check("rst_bus_req", 32'(bus_req_o), 0);
    check("rst_acks", {29'd0, if_ack_o, d_ack_o, timeout_o}, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_rdata", if_rdata_o | d_rdata_o, 0);
    rst = 1'b0;
    tick();

    // Stray bus ack while idle must be ignored.
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    tick();
    bus_ack_i = 1'b0;
    check("idle_ack_ignored", {30'd0, if_ack_o, d_ack_o}, 0);
    check("idle_no_req", 32'(bus_req_o), 0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_d) begin
        d_req_i = 1; d_we_i = vecs[i].we; d_addr_i = vecs[i].addr;
        d_wdata_i = vecs[i].wdata; d_sel_i = vecs[i].sel; if_addr_i = 32'hFFFF_FFF0;
      end else begin
        if_req_i = 1; if_addr_i = vecs[i].addr;
        d_we_i = vecs[i].we; d_wdata_i = vecs[i].wdata; d_sel_i = vecs[i].sel;
        d_addr_i = 32'hEEEE_EEE0;
      end
      tick();
      check($sformatf("v%0d_bus_req", i), 32'(bus_req_o), 1);
      check($sformatf("v%0d_bus_we", i), 32'(bus_we_o), 32'(vecs[i].exp_we));
      check($sformatf("v%0d_bus_addr", i), bus_addr_o, vecs[i].addr);
      check($sformatf("v%0d_bus_wdata", i), bus_wdata_o, vecs[i].exp_wdata);
      check($sformatf("v%0d_bus_sel", i), 32'(bus_sel_o), 32'(vecs[i].exp_sel));
      for (int w = 0; w < vecs[i].waits; w++) begin
        check($sformatf("v%0d_stall_w%0d", i, w),
              32'(vecs[i].is_d ? stallreq_mem_o : stallreq_if_o), 1);
        tick();
        check($sformatf("v%0d_hold_w%0d", i, w), {bus_addr_o[30:0], bus_req_o},
              {vecs[i].addr[30:0], 1'b1});
      end
      bus_ack_i = 1; bus_rdata_i = vecs[i].rdata;
      tick();
      bus_ack_i = 0; bus_rdata_i = 32'h0;
      if (vecs[i].is_d) model_d_rdata = vecs[i].rdata;
      else model_if_rdata = vecs[i].rdata;
      check($sformatf("v%0d_acks", i), {30'd0, if_ack_o, d_ack_o},
            vecs[i].is_d ? 32'd1 : 32'd2);
      check($sformatf("v%0d_if_rdata", i), if_rdata_o, model_if_rdata);
      check($sformatf("v%0d_d_rdata", i), d_rdata_o, model_d_rdata);
      check($sformatf("v%0d_bus_req_drop", i), 32'(bus_req_o), 0);
      check($sformatf("v%0d_stall_off", i), {30'd0, stallreq_if_o, stallreq_mem_o}, 0);
      if_req_i = 0; d_req_i = 0;
      tick();
      check($sformatf("v%0d_ack_pulse", i), {29'd0, if_ack_o, d_ack_o, timeout_o}, 0);
    end

    // Both ports held: expect D,D,D,D,IF,D and 3-cycle period on a zero-wait bus.
    if_addr_i = 32'h0000_0100; d_addr_i = 32'h0000_2000; d_we_i = 0; d_sel_i = 4'hF;
    if_req_i = 1; d_req_i = 1;
    for (int g = 0; g < 6; g++) begin
      exp_is_d = (g != 4);
      wait_bus_req($sformatf("g%0d_granted", g));
      check($sformatf("g%0d_port", g), bus_addr_o, exp_is_d ? 32'h2000 : 32'h100);
      bus_ack_i = 1; bus_rdata_i = 32'hA000_0000 + 32'(g);
      tick();
      bus_ack_i = 0;
      if (exp_is_d) model_d_rdata = 32'hA000_0000 + 32'(g);
      else model_if_rdata = 32'hA000_0000 + 32'(g);
      check($sformatf("g%0d_acks", g), {30'd0, if_ack_o, d_ack_o}, exp_is_d ? 32'd1 : 32'd2);
      check($sformatf("g%0d_rdata", g), exp_is_d ? d_rdata_o : if_rdata_o,
            32'hA000_0000 + 32'(g));
      tick();
      check($sformatf("g%0d_resp_no_grant", g), 32'(bus_req_o), 0);
      tick();
      check($sformatf("g%0d_regrant", g), 32'(bus_req_o), 1);
    end
    // Finish the pending grant (g=6 would be D) so the port settles.
    bus_ack_i = 1; bus_rdata_i = 32'hBBBB_0006;
    tick();
    bus_ack_i = 0; model_d_rdata = 32'hBBBB_0006;
    if_req_i = 0; d_req_i = 0;
    tick();
    tick();

    // Timeout: bus never acks.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h0000_4000;
    tick();
    busy_cycles = 0;
    while (bus_req_o && busy_cycles < 400) begin
      busy_cycles++;
      tick();
    end
    check("tmo_busy_cycles", 32'(busy_cycles), 255);
    check("tmo_flags", {29'd0, d_ack_o, timeout_o, if_ack_o}, 32'b110);
    check("tmo_rdata_zero", d_rdata_o, 0);
    check("tmo_stall_off", 32'(stallreq_mem_o), 0);
    d_req_i = 0;
    tick();
    check("tmo_pulse", {30'd0, d_ack_o, timeout_o}, 0);
    tick();

    // Ack arriving on the last waiting cycle completes normally.
    d_req_i = 1; d_addr_i = 32'h0000_4004;
    tick();
    for (int w = 0; w < 254; w++) tick();
    check("ackt_still_busy", 32'(bus_req_o), 1);
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_F00D;
    tick();
    bus_ack_i = 0;
    check("ackt_flags", {30'd0, d_ack_o, timeout_o}, 32'b10);
    check("ackt_rdata", d_rdata_o, 32'hCAFE_F00D);
    d_req_i = 0;
    tick();
    tick();

    // Reset during a fetch aborts it; a fresh fetch then completes.
    if_req_i = 1; if_addr_i = 32'h0000_0200;
    tick();
    check("rstb_busy", 32'(bus_req_o), 1);
    tick();
    rst = 1;
    tick();
    check("rstb_bus_req", 32'(bus_req_o), 0);
    check("rstb_acks", {29'd0, if_ack_o, d_ack_o, timeout_o}, 0);
    rst = 0;
    tick();
    check("rstb_regrant", {bus_addr_o[30:0], bus_req_o}, {31'h200, 1'b1});
    bus_ack_i = 1; bus_rdata_i = 32'h2468_ACE0;
    tick();
    bus_ack_i = 0;
    check("rstb_fetch_ack", {30'd0, if_ack_o, d_ack_o}, 32'd2);
    check("rstb_fetch_rdata", if_rdata_o, 32'h2468_ACE0);
    if_req_i = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
